// File: rtl/processor_pkg.sv
// Shared types and constants for the processor's instruction-memory loader.
package processor_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    RUN   = 2'd3
  } load_state_t;

  // Instruction that terminates a program; it is itself stored in memory.
  localparam logic [15:0] HALT_WORD = 16'h5000;

  // Number of words in the processor's instruction memory.
  localparam int IMEM_DEPTH = 128;

endpackage

// File: rtl/imem_loader_if.sv
// Word stream in, instruction-memory write port out.
// The master side supplies instruction words and observes the memory writes;
// the slave side is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic              In_Valid;
  logic [DATA_W-1:0] In_Data;
  logic              In_Ready;
  logic              Mem_Wr;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data;

  modport master (
    output In_Valid, In_Data,
    input  In_Ready, Mem_Wr, Mem_Addr, Mem_Data
  );

  modport slave (
    input  In_Valid, In_Data,
    output In_Ready, Mem_Wr, Mem_Addr, Mem_Data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams words into the 128-entry instruction
// memory, optionally zero-fills the tail after the halt word, and only then
// releases the processor from reset.
module imem_loader
  import processor_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int CLEAR_REST = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  imem_loader_if.slave    bus,
  output logic            Proc_Run,
  output logic            Done,
  output logic            Error,
  output logic [ADDR_W:0] Word_Count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] HALT_DATA = DATA_W'(HALT_WORD);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  load_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              done_reg, error_reg, proc_run_reg;
  logic              mem_wr_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_data_reg;

  logic accept;      // handshake completes this cycle
  logic clear_wr;    // zero-fill write issued this cycle
  logic start_load;  // Start honoured (only from IDLE or RUN)
  logic load_fail;   // memory filled without a halt word

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode and per-cycle strobes.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    clear_wr   = 1'b0;
    start_load = 1'b0;
    load_fail  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          start_load = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        accept = bus.In_Valid;
        if (accept) begin
          if (bus.In_Data == HALT_DATA) begin
            // A halt landing in the last slot leaves nothing to clear.
            state_next = (CLEAR_REST != 0 && addr_reg != LAST_ADDR) ? CLEAR : RUN;
          end else if (addr_reg == LAST_ADDR) begin
            load_fail  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      CLEAR: begin
        clear_wr = 1'b1;
        if (addr_reg == LAST_ADDR) state_next = RUN;
      end
      RUN: begin
        if (Start) begin
          start_load = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/count tracking, registered memory write port and status flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_reg     <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      proc_run_reg <= 1'b0;
      mem_wr_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
    end else begin
      mem_wr_reg <= accept || clear_wr;
      if (accept) begin
        mem_addr_reg <= addr_reg;
        mem_data_reg <= bus.In_Data;
        addr_reg     <= addr_reg + ADDR_ONE;
        count_reg    <= count_reg + COUNT_ONE;
      end else if (clear_wr) begin
        mem_addr_reg <= addr_reg;
        mem_data_reg <= '0;
        addr_reg     <= addr_reg + ADDR_ONE;
      end
      if (start_load) begin
        addr_reg  <= '0;
        count_reg <= '0;
        done_reg  <= 1'b0;
        error_reg <= 1'b0;
      end
      if (load_fail) begin
        error_reg <= 1'b1;
        done_reg  <= 1'b1;
      end
      if (state_next == RUN) done_reg <= 1'b1;
      // Lags the RUN state by a cycle so the final memory write has landed
      // before the processor fetches; drops immediately on a new Start.
      proc_run_reg <= (state_reg == RUN) && (state_next == RUN);
    end
  end

  assign bus.In_Ready = (state_reg == LOAD);
  assign bus.Mem_Wr   = mem_wr_reg;
  assign bus.Mem_Addr = mem_addr_reg;
  assign bus.Mem_Data = mem_data_reg;
  assign Proc_Run     = proc_run_reg;
  assign Done         = done_reg;
  assign Error        = error_reg;
  assign Word_Count   = count_reg;

endmodule
